// File: rtl/gt_int_serial_ctrl.sv
// Bit-serial signed "greater than" / equality comparator.
// The sign bit is examined first, then magnitude bits from MSB-1 down to 0.
// The first differing bit decides the result; with EARLY_EXIT set the
// compare finishes as soon as that happens, otherwise it always walks
// every bit so the latency is fixed.
module gt_int_serial_ctrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             Y,
  output logic             EQ
);

  localparam int unsigned      IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WIDTH - 2);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam bit               EE       = (EARLY_EXIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIGN = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             decided_r, decided_s;
  logic             result_r, result_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             y_r, y_s;
  logic             eq_r, eq_s;
  logic             sign_diff_s;
  logic             bit_diff_s;

  // State and datapath registers; reset wins over everything, including an in-flight compare
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      idx_r     <= IDX_ZERO;
      decided_r <= 1'b0;
      result_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      y_r       <= 1'b0;
      eq_r      <= 1'b0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      idx_r     <= idx_s;
      decided_r <= decided_s;
      result_r  <= result_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      y_r       <= y_s;
      eq_r      <= eq_s;
    end
  end

  // Next-state, serial compare step and next values of the registered outputs
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    idx_s       = idx_r;
    decided_s   = decided_r;
    result_s    = result_r;
    sign_diff_s = a_r[WIDTH-1] ^ b_r[WIDTH-1];
    bit_diff_s  = a_r[idx_r] ^ b_r[idx_r];

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          a_s       = A;
          b_s       = B;
          decided_s = 1'b0;
          result_s  = 1'b0;
          state_s   = ST_SIGN;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SIGN: begin
        // Differing sign bits: A > B exactly when B is the negative one
        if (sign_diff_s) begin
          decided_s = 1'b1;
          result_s  = b_r[WIDTH-1];
        end else begin
          decided_s = decided_r;
          result_s  = result_r;
        end
        if (decided_s && EE) begin
          state_s = ST_DONE;
        end else begin
          idx_s   = IDX_TOP;
          state_s = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Only the first differing magnitude bit may set the result
        if (!decided_r && bit_diff_s) begin
          decided_s = 1'b1;
          result_s  = a_r[idx_r];
        end else begin
          decided_s = decided_r;
          result_s  = result_r;
        end
        if ((decided_s && EE) || (idx_r == IDX_ZERO)) begin
          state_s = ST_DONE;
        end else begin
          idx_s   = idx_r - IDX_ONE;
          state_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
    if (state_s == ST_DONE) begin
      y_s  = result_s;
      eq_s = ~decided_s;
    end else begin
      y_s  = y_r;
      eq_s = eq_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Y    = y_r;
  assign EQ   = eq_r;

endmodule

// File: tb/tb_gt_int_serial_ctrl.sv
// Directed and randomized bench for gt_int_serial_ctrl. Six instances cover
// WIDTH 2/8/32 with EARLY_EXIT 1/0; each has its own operand and start lines
// so the randomized sweeps can run side by side.
// Cycle numbering: the accept cycle is 0, so the first cycle after the
// accepting edge is cycle 1.
module tb_gt_int_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [6];
  logic [31:0] a_v [6];
  logic [31:0] b_v [6];
  wire  [5:0]  busy_v, done_v, y_v, eq_v;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  gt_int_serial_ctrl #(.WIDTH(2), .EARLY_EXIT(1)) u_w2_ee1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0][1:0]), .B(b_v[0][1:0]),
    .busy(busy_v[0]), .done(done_v[0]), .Y(y_v[0]), .EQ(eq_v[0]));
  gt_int_serial_ctrl #(.WIDTH(2), .EARLY_EXIT(0)) u_w2_ee0 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1][1:0]), .B(b_v[1][1:0]),
    .busy(busy_v[1]), .done(done_v[1]), .Y(y_v[1]), .EQ(eq_v[1]));
  gt_int_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(1)) u_w8_ee1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2][7:0]), .B(b_v[2][7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .Y(y_v[2]), .EQ(eq_v[2]));
  gt_int_serial_ctrl #(.WIDTH(8), .EARLY_EXIT(0)) u_w8_ee0 (
    .clk(clk), .rst(rst), .start(start_v[3]), .A(a_v[3][7:0]), .B(b_v[3][7:0]),
    .busy(busy_v[3]), .done(done_v[3]), .Y(y_v[3]), .EQ(eq_v[3]));
  gt_int_serial_ctrl #(.WIDTH(32), .EARLY_EXIT(1)) u_w32_ee1 (
    .clk(clk), .rst(rst), .start(start_v[4]), .A(a_v[4]), .B(b_v[4]),
    .busy(busy_v[4]), .done(done_v[4]), .Y(y_v[4]), .EQ(eq_v[4]));
  gt_int_serial_ctrl #(.WIDTH(32), .EARLY_EXIT(0)) u_w32_ee0 (
    .clk(clk), .rst(rst), .start(start_v[5]), .A(a_v[5]), .B(b_v[5]),
    .busy(busy_v[5]), .done(done_v[5]), .Y(y_v[5]), .EQ(eq_v[5]));

  // Waits for idle, issues one compare, scrambles the operands after accept
  // and returns the cycle in which done was seen (-1 if it never came).
  task automatic issue(input int inst, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    int guard = 0;
    while (busy_v[inst] === 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    a_v[inst] = a;
    b_v[inst] = b;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    a_v[inst] = ~a;
    b_v[inst] = $urandom;
    cyc = 1;
    while (done_v[inst] !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done_v[inst] !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({busy_v[i], done_v[i], y_v[i], eq_v[i]} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: busy/done/Y/EQ got %b expected 0000", i,
                 {busy_v[i], done_v[i], y_v[i], eq_v[i]});
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    int         tl [6];
    logic       ty [6];
    logic       te [6];
    int         lat;
    ta = '{8'h05, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h01};
    tb = '{8'h03, 8'h7F, 8'hFF, 8'h00, 8'hFF, 8'h00};
    tl = '{7, 2, 9, 2, 2, 9};
    ty = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    te = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(2, {24'h0, ta[i]}, {24'h0, tb[i]}, lat);
      n_cmp++;
      if (lat !== tl[i]) begin
        n_bad++;
        $display("FAIL basic[%0d] latency: got %0d expected %0d", i, lat, tl[i]);
      end
      n_cmp++;
      if ({y_v[2], eq_v[2]} !== {ty[i], te[i]}) begin
        n_bad++;
        $display("FAIL basic[%0d] Y/EQ: got %b expected %b", i, {y_v[2], eq_v[2]}, {ty[i], te[i]});
      end
    end
  endtask

  task automatic test_full_latency();
    logic [7:0] ta [5];
    logic [7:0] tb [5];
    logic       ty [5];
    logic       te [5];
    int         lat;
    ta = '{8'h7F, 8'hFE, 8'h40, 8'h80, 8'h33};
    tb = '{8'h80, 8'hFF, 8'h20, 8'h7F, 8'h33};
    ty = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(3, {24'h0, ta[i]}, {24'h0, tb[i]}, lat);
      n_cmp++;
      if (lat !== 9) begin
        n_bad++;
        $display("FAIL full[%0d] latency: got %0d expected 9", i, lat);
      end
      n_cmp++;
      if ({y_v[3], eq_v[3]} !== {ty[i], te[i]}) begin
        n_bad++;
        $display("FAIL full[%0d] Y/EQ: got %b expected %b", i, {y_v[3], eq_v[3]}, {ty[i], te[i]});
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(2, 32'h05, 32'h03, lat);
    @(posedge clk); #1;
    n_cmp++;
    if ({done_v[2], y_v[2], eq_v[2]} !== 3'b010) begin
      n_bad++;
      $display("FAIL hold_after_done: done/Y/EQ got %b expected 010", {done_v[2], y_v[2], eq_v[2]});
    end
    a_v[2] = 32'hFF; b_v[2] = 32'hFF; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    n_cmp++;
    if ({busy_v[2], y_v[2], eq_v[2]} !== 3'b110) begin
      n_bad++;
      $display("FAIL hold_while_busy: busy/Y/EQ got %b expected 110", {busy_v[2], y_v[2], eq_v[2]});
    end
    lat = 1;
    while (done_v[2] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if ({lat, y_v[2], eq_v[2]} !== {32'd9, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL hold_next_result: cycle %0d Y=%b EQ=%b expected cycle 9 Y=0 EQ=1",
               lat, y_v[2], eq_v[2]);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int seen = 0;
    @(posedge clk); #1;
    a_v[2] = 32'h10; b_v[2] = 32'h01; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_v[2] = 32'h00; b_v[2] = 32'h7F; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    lat = 4;
    while (done_v[2] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++;
    if ({lat, y_v[2], eq_v[2]} !== {32'd5, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL busy_ignore: cycle %0d Y=%b EQ=%b expected cycle 5 Y=1 EQ=0",
               lat, y_v[2], eq_v[2]);
    end
    // start raised during the done cycle must be dropped
    a_v[2] = 32'h00; b_v[2] = 32'h7F; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy_v[2] !== 1'b0 || done_v[2] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0 || y_v[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL done_cycle_ignore: active cycles %0d Y=%b expected 0 cycles Y=1", seen, y_v[2]);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen = 0;
    a_v[2] = 32'hFF; b_v[2] = 32'hFF; start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_v[2], done_v[2], y_v[2], eq_v[2]} !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_state: busy/done/Y/EQ got %b expected 0000",
               {busy_v[2], done_v[2], y_v[2], eq_v[2]});
    end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[2] !== 1'b0 || busy_v[2] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL abort_no_done: active cycles got %0d expected 0", seen);
    end
    issue(2, 32'h05, 32'h03, lat);
    n_cmp++;
    if ({lat, y_v[2], eq_v[2]} !== {32'd7, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL after_abort: cycle %0d Y=%b EQ=%b expected cycle 7 Y=1 EQ=0",
               lat, y_v[2], eq_v[2]);
    end
  endtask

  task automatic sweep(input int inst, input int w, input bit ee, input int n);
    logic [31:0]        mask, a, b, diff;
    logic [31:0]        ext [4];
    logic signed [31:0] sa, sb;
    logic               exp_y, exp_eq;
    int                 k, lat, exp_lat;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    ext[0] = 32'd0;
    ext[1] = mask;
    ext[2] = 32'd1 << (w - 1);
    ext[3] = (32'd1 << (w - 1)) - 32'd1;
    for (int p = 0; p < n; p++) begin
      case ($urandom_range(3, 0))
        0: begin a = $urandom & mask; b = $urandom & mask; end
        1: begin a = $urandom & mask; b = a; end
        2: begin a = $urandom & mask; b = a ^ (32'd1 << $urandom_range(w - 1, 0)); end
        default: begin a = ext[$urandom_range(3, 0)]; b = ext[$urandom_range(3, 0)]; end
      endcase
      sa = $signed(a << (32 - w));
      sa = sa >>> (32 - w);
      sb = $signed(b << (32 - w));
      sb = sb >>> (32 - w);
      exp_y  = (sa > sb);
      exp_eq = (a == b);
      diff   = a ^ b;
      k = -1;
      for (int i = 31; i >= 0; i--) if (k < 0 && diff[i]) k = i;
      exp_lat = (exp_eq || !ee) ? (w + 1) : (2 + (w - 1 - k));
      issue(inst, a, b, lat);
      n_cmp++;
      if (lat !== exp_lat) begin
        n_bad++;
        $display("FAIL sweep w%0d ee%0d latency A=%h B=%h: got %0d expected %0d", w, ee, a, b, lat, exp_lat);
      end
      n_cmp++;
      if (y_v[inst] !== exp_y) begin
        n_bad++;
        $display("FAIL sweep w%0d ee%0d Y A=%h B=%h: got %b expected %b", w, ee, a, b, y_v[inst], exp_y);
      end
      n_cmp++;
      if (eq_v[inst] !== exp_eq) begin
        n_bad++;
        $display("FAIL sweep w%0d ee%0d EQ A=%h B=%h: got %b expected %b", w, ee, a, b, eq_v[inst], exp_eq);
      end
    end
  endtask

  task automatic test_random_sweep();
    fork
      sweep(0, 2, 1'b1, 2500);
      sweep(1, 2, 1'b0, 2500);
      sweep(2, 8, 1'b1, 2000);
      sweep(3, 8, 1'b0, 2000);
      sweep(4, 32, 1'b1, 1000);
      sweep(5, 32, 1'b0, 500);
    join
  endtask

  // Test sequence
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = 32'd0;
      b_v[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_full_latency();
    test_hold();
    test_busy_ignore();
    test_reset_abort();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so a stuck design cannot hang the run
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/gt_int_serial_ctrl.md
GT_INT_SERIAL_CTRL -- requirements
Module: gt_int_serial_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits, legal range WIDTH >= 2.
REQ-002 SHALL have parameter EARLY_EXIT, default 1; 1 = finish at the first decisive bit, 0 = always use full latency.
REQ-003 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  request a compare; accepted only while busy=0.
REQ-006 SHALL have A  input  WIDTH  signed two's-complement operand; sampled on the accepted start.
REQ-007 SHALL have B  input  WIDTH  signed two's-complement operand; sampled on the accepted start.
REQ-008 SHALL have busy  output  1  high from the cycle after accept through the done cycle.
REQ-009 SHALL have done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have Y  output  1  result of signed A > B.
REQ-011 SHALL have EQ  output  1  result of A == B.

Function
REQ-012 SHALL implement states IDLE, SIGN, SCAN and DONE, with busy=1 in every state except IDLE.
REQ-013 IDLE: on start=1, SHALL latch A and B into internal registers, clear the decided flag and the result, and go to SIGN.
REQ-014 SIGN: SHALL compare bit WIDTH-1 and, if the bits differ, set decided=1 and result=B[WIDTH-1].
REQ-015 SIGN exit: if decided and EARLY_EXIT=1, SHALL go to DONE; otherwise SHALL load idx=WIDTH-2 and go to SCAN.
REQ-016 SCAN: if not yet decided and bit idx of the latched operands differs, SHALL set decided=1 and result=latched A[idx].
REQ-017 SCAN exit: SHALL go to DONE if (decided and EARLY_EXIT=1) or idx==0; otherwise SHALL decrement idx.
REQ-018 Once decided=1, later bits SHALL NOT change result (matters for EARLY_EXIT=0).
REQ-019 DONE: SHALL drive done=1 for exactly one cycle, update Y=result and EQ=~decided, then return to IDLE.
REQ-020 Y and EQ SHALL change only in the DONE cycle and SHALL hold their value until the next DONE or reset.
REQ-021 Latency, with the accept cycle numbered 0: bit k decisive -> done in cycle 2+(WIDTH-1-k) when EARLY_EXIT=1.
REQ-022 Latency, full: done SHALL be in cycle WIDTH+1 when operands are equal or EARLY_EXIT=0.
REQ-023 start while busy=1, including in the DONE cycle, SHALL be ignored with no queuing.
REQ-024 Changes on A or B after accept SHALL NOT affect the in-flight result.
REQ-025 idx SHALL be ceil(log2(WIDTH)) bits wide and SHALL never underflow; idx==0 always terminates SCAN.
REQ-026 For WIDTH=2, SCAN SHALL execute exactly one cycle (idx=0).
REQ-027 Signed semantics SHALL match two's complement: most-negative < all, -1 < 0, and equal values give Y=0, EQ=1.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, Y=0, EQ=0, idx=0, decided=0 and result=0.
REQ-029 rst SHALL have priority over start and over any in-flight state; an aborted compare SHALL produce no done pulse.
REQ-030 The first start accepted after rst deasserts SHALL behave identically to one issued after power-up reset.

Verification
REQ-031 WIDTH=8, EARLY_EXIT=1: A=0x05, B=0x03 -> decisive bit 2, done in cycle 7, Y=1, EQ=0.
REQ-032 WIDTH=8, EARLY_EXIT=1: A=0x80 (-128), B=0x7F (127) -> sign bits differ, done in cycle 2, Y=0, EQ=0.
REQ-033 WIDTH=8, EARLY_EXIT=1: A=B=0xFF -> done in cycle 9, Y=0, EQ=1.
REQ-034 WIDTH=8, EARLY_EXIT=0: A=0x7F, B=0x80 -> done in cycle 9 (not cycle 2), Y=1; A=0xFE (-2), B=0xFF (-1) -> done in cycle 9, Y=0.
REQ-035 WIDTH=8: start A=0x10, B=0x01; in cycle 3 pulse start with A=0x00, B=0x7F -> ignored, done in cycle 5 with Y=1.
REQ-036 WIDTH=8: assert rst in cycle 4 of a compare -> no done pulse, busy=0, Y=0, EQ=0; the next start completes normally.
REQ-037 The bench SHALL run a randomized sweep of at least 10,000 operand pairs for WIDTH in {2, 8, 32} and both EARLY_EXIT values against a signed reference comparison, checking Y, EQ and done latency on every pair.
